// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB parameterised bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_SLV = 2;
  localparam int DEF_TO_CYC  = 16;

  // Slave-index width: ceil(log2(n)), never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_resp_mux.sv
// Selects one slave's PRDATA/PREADY/PSLVERR by index; flags indices
// beyond the populated slave range as a decode miss.
module apb_resp_mux
  import apb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SEL_W   = sel_width(DEF_NUM_SLV)
) (
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [NUM_SLV*DATA_W-1:0] i_prdata_bus,
  input  logic [NUM_SLV-1:0]        i_pready_bus,
  input  logic [NUM_SLV-1:0]        i_pslverr_bus,
  output logic [DATA_W-1:0]         o_prdata,
  output logic                      o_pready,
  output logic                      o_pslverr,
  output logic                      o_miss
);

  logic [31:0] w_idx;

  assign w_idx  = 32'(i_sel);
  assign o_miss = (w_idx >= 32'(NUM_SLV));

  // Pick the indexed slave's response; a miss yields all zeros so
  // unselected slaves can never complete or corrupt a transfer.
  always_comb begin
    o_prdata  = '0;
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (w_idx == k) begin
        o_prdata  = i_prdata_bus[k*DATA_W +: DATA_W];
        o_pready  = i_pready_bus[k];
        o_pslverr = i_pslverr_bus[k];
      end
    end
  end

endmodule

// File: rtl/apb_param_bridge.sv
// Request/response to APB master bridge with one-hot slave decode,
// wait-state timeout, decode-miss error and back-to-back transfers.
module apb_param_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SEL_W   = sel_width(NUM_SLV),
  parameter int TO_CYC  = DEF_TO_CYC
) (
  input  logic                      PCLK,
  input  logic                      PRST,
  input  logic                      transfer,
  input  logic                      RD_WR,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA_bus,
  input  logic [NUM_SLV-1:0]        PREADY_bus,
  input  logic [NUM_SLV-1:0]        PSLVERR_bus
);

  localparam int CNT_W = $clog2(TO_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  apb_state_t         r_state;
  apb_state_t         w_next;
  logic [ADDR_W-1:0]  r_paddr;
  logic [DATA_W-1:0]  r_pwdata;
  logic               r_pwrite;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rd_data;

  logic [SEL_W-1:0]   w_sel;
  logic [DATA_W-1:0]  w_prdata;
  logic               w_pready;
  logic               w_pslverr;
  logic               w_miss;
  logic               w_in_access;
  logic               w_timeout;
  logic               w_done;
  logic               w_err;
  logic               w_req_ready;
  logic               w_accept;
  logic [NUM_SLV-1:0] w_psel;

  assign w_sel = r_paddr[ADDR_W-1 -: SEL_W];

  apb_resp_mux #(
    .DATA_W  (DATA_W),
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_resp_mux (
    .i_sel         (w_sel),
    .i_prdata_bus  (PRDATA_bus),
    .i_pready_bus  (PREADY_bus),
    .i_pslverr_bus (PSLVERR_bus),
    .o_prdata      (w_prdata),
    .o_pready      (w_pready),
    .o_pslverr     (w_pslverr),
    .o_miss        (w_miss)
  );

  // Mux reports pready=0 on a miss, so any completion without pready
  // (miss or timeout) is an error and PSLVERR only counts with pready.
  assign w_in_access = (r_state == ACCESS);
  assign w_timeout   = w_in_access && !w_pready && (r_cnt == CNT_LAST);
  assign w_done      = w_in_access && (w_miss || w_pready || w_timeout);
  assign w_err       = !w_pready || w_pslverr;
  assign w_accept    = transfer && w_req_ready;

  // Next-state and request handshake.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (transfer) w_next = SETUP;
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (w_done) begin
          w_req_ready = 1'b1;
          w_next      = transfer ? SETUP : IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // One-hot select while a transfer is on the bus; nothing on a miss.
  always_comb begin
    w_psel = '0;
    if ((r_state != IDLE) && !w_miss) begin
      for (int unsigned k = 0; k < NUM_SLV; k++) begin
        w_psel[k] = (32'(w_sel) == k);
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Capture the request on acceptance; held through SETUP and ACCESS.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (w_accept) begin
      r_paddr  <= req_addr;
      r_pwdata <= req_wdata;
      r_pwrite <= ~RD_WR;
    end
  end

  // Wait-state counter: cleared in SETUP so each ACCESS starts at zero.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST)                     r_cnt <= '0;
    else if (r_state == SETUP)    r_cnt <= '0;
    else if (w_in_access && !w_done) r_cnt <= r_cnt + 1'b1;
  end

  // Registered completion pulse with error and read data.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rsp_valid <= w_done;
      r_rsp_err   <= w_done && w_err;
      r_rd_data   <= (w_done && w_pready && !r_pwrite) ? w_prdata : '0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rd_data   = r_rd_data;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PENABLE   = w_in_access;
  assign PSEL      = w_psel;

endmodule

// File: tb/tb_apb_param_bridge.sv
// Directed bench: dut_a uses two slaves, dut_b three slaves (index 3 misses).
module tb_apb_param_bridge;

  logic PCLK = 1'b0;
  logic PRST = 1'b1;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  logic        a_transfer, a_rd_wr;
  logic [8:0]  a_addr;
  logic [7:0]  a_wdata;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [7:0]  a_rd_data;
  logic [8:0]  a_paddr;
  logic [7:0]  a_pwdata;
  logic        a_pwrite, a_penable;
  logic [1:0]  a_psel;
  logic [15:0] a_prdata;
  logic [1:0]  a_pready, a_pslverr;

  logic        b_transfer, b_rd_wr;
  logic [8:0]  b_addr;
  logic [7:0]  b_wdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [7:0]  b_rd_data;
  logic [8:0]  b_paddr;
  logic [7:0]  b_pwdata;
  logic        b_pwrite, b_penable;
  logic [2:0]  b_psel;
  logic [23:0] b_prdata;
  logic [2:0]  b_pready, b_pslverr;

  apb_param_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TO_CYC(16)) dut_a (
    .PCLK(PCLK), .PRST(PRST), .transfer(a_transfer), .RD_WR(a_rd_wr),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rd_data(a_rd_data),
    .PADDR(a_paddr), .PWDATA(a_pwdata), .PWRITE(a_pwrite), .PENABLE(a_penable),
    .PSEL(a_psel), .PRDATA_bus(a_prdata), .PREADY_bus(a_pready), .PSLVERR_bus(a_pslverr)
  );

  apb_param_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .SEL_W(2), .TO_CYC(16)) dut_b (
    .PCLK(PCLK), .PRST(PRST), .transfer(b_transfer), .RD_WR(b_rd_wr),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rd_data(b_rd_data),
    .PADDR(b_paddr), .PWDATA(b_pwdata), .PWRITE(b_pwrite), .PENABLE(b_penable),
    .PSEL(b_psel), .PRDATA_bus(b_prdata), .PREADY_bus(b_pready), .PSLVERR_bus(b_pslverr)
  );

  // Inputs are driven just after the falling edge and outputs checked #1 later,
  // so each step is one clock cycle with its inputs already applied.
  task automatic test_reset();
    a_transfer = 0; a_rd_wr = 0; a_addr = '0; a_wdata = '0;
    a_prdata = '0; a_pready = '0; a_pslverr = '0;
    b_transfer = 0; b_rd_wr = 0; b_addr = '0; b_wdata = '0;
    b_prdata = '0; b_pready = '0; b_pslverr = '0;
    PRST = 1;
    @(negedge PCLK); @(negedge PCLK); #1;
    total++; if (a_psel !== 2'b00) begin bad++; $display("FAIL rst_psel got=%b want=00", a_psel); end
    total++; if (a_penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b want=0", a_penable); end
    total++; if ({a_paddr, a_pwdata, a_pwrite} !== 18'h0) begin bad++; $display("FAIL rst_bus got=%h/%h/%b want=0", a_paddr, a_pwdata, a_pwrite); end
    total++; if ({a_rsp_valid, a_rsp_err, a_rd_data} !== 10'h0) begin bad++; $display("FAIL rst_rsp got=%b/%b/%h want=0", a_rsp_valid, a_rsp_err, a_rd_data); end
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", a_req_ready); end
    total++; if (b_psel !== 3'b000) begin bad++; $display("FAIL rst_b_psel got=%b want=000", b_psel); end
    @(negedge PCLK); PRST = 0;
  endtask

  task automatic test_write();
    @(negedge PCLK); a_transfer = 1; a_rd_wr = 0; a_addr = 9'h105; a_wdata = 8'hA5; #1;
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL wr_idle_ready got=%b want=1", a_req_ready); end
    @(negedge PCLK); a_transfer = 0; a_pready = 2'b10; #1;
    total++; if (a_psel !== 2'b10) begin bad++; $display("FAIL wr_setup_psel got=%b want=10", a_psel); end
    total++; if (a_penable !== 1'b0) begin bad++; $display("FAIL wr_setup_penable got=%b want=0", a_penable); end
    total++; if ({a_paddr, a_pwdata, a_pwrite} !== {9'h105, 8'hA5, 1'b1}) begin bad++; $display("FAIL wr_setup_bus got=%h/%h/%b want=105/a5/1", a_paddr, a_pwdata, a_pwrite); end
    @(negedge PCLK); #1;
    total++; if ({a_penable, a_psel, a_req_ready, a_rsp_valid} !== 5'b1_10_1_0) begin bad++; $display("FAIL wr_access got=%b%b%b%b want=11010", a_penable, a_psel, a_req_ready, a_rsp_valid); end
    @(negedge PCLK); a_pready = 2'b00; #1;
    total++; if ({a_rsp_valid, a_rsp_err, a_rd_data} !== {1'b1, 1'b0, 8'h00}) begin bad++; $display("FAIL wr_rsp got=%b/%b/%h want=1/0/00", a_rsp_valid, a_rsp_err, a_rd_data); end
    total++; if ({a_psel, a_penable} !== 3'b000) begin bad++; $display("FAIL wr_idle_bus got=%b/%b want=00/0", a_psel, a_penable); end
    @(negedge PCLK); #1;
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse got=%b want=0", a_rsp_valid); end
  endtask

  task automatic test_read_wait();
    @(negedge PCLK); a_transfer = 1; a_rd_wr = 1; a_addr = 9'h010; a_prdata = {8'hFF, 8'h3C}; #1;
    // Slave 1 is ready and slave 0 flags error while waiting: neither may matter.
    @(negedge PCLK); a_transfer = 0; a_pready = 2'b10; a_pslverr = 2'b01; #1;
    total++; if ({a_psel, a_penable, a_pwrite} !== 4'b01_0_0) begin bad++; $display("FAIL rd_setup got=%b/%b/%b want=01/0/0", a_psel, a_penable, a_pwrite); end
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      total++; if ({a_penable, a_psel, a_req_ready, a_rsp_valid, a_paddr} !== {1'b1, 2'b01, 1'b0, 1'b0, 9'h010}) begin bad++; $display("FAIL rd_wait%0d got=%b/%b/%b/%b/%h want=1/01/0/0/010", i, a_penable, a_psel, a_req_ready, a_rsp_valid, a_paddr); end
    end
    @(negedge PCLK); a_pready = 2'b11; a_pslverr = 2'b00; #1;
    total++; if ({a_penable, a_req_ready} !== 2'b11) begin bad++; $display("FAIL rd_complete got=%b/%b want=1/1", a_penable, a_req_ready); end
    @(negedge PCLK); a_pready = 2'b00; #1;
    total++; if ({a_rsp_valid, a_rsp_err, a_rd_data} !== {1'b1, 1'b0, 8'h3C}) begin bad++; $display("FAIL rd_rsp got=%b/%b/%h want=1/0/3c", a_rsp_valid, a_rsp_err, a_rd_data); end
  endtask

  task automatic test_decode_miss();
    @(negedge PCLK); b_transfer = 1; b_rd_wr = 1; b_addr = 9'h180; b_prdata = 24'hABCDEF; b_pready = 3'b111; #1;
    @(negedge PCLK); b_transfer = 0; #1;
    total++; if ({b_psel, b_penable} !== 4'b000_0) begin bad++; $display("FAIL miss_setup got=%b/%b want=000/0", b_psel, b_penable); end
    @(negedge PCLK); #1;
    total++; if ({b_psel, b_penable, b_req_ready} !== 5'b000_1_1) begin bad++; $display("FAIL miss_access got=%b/%b/%b want=000/1/1", b_psel, b_penable, b_req_ready); end
    @(negedge PCLK); #1;
    total++; if ({b_rsp_valid, b_rsp_err, b_rd_data} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL miss_rsp got=%b/%b/%h want=1/1/00", b_rsp_valid, b_rsp_err, b_rd_data); end
    b_pready = 3'b000;
  endtask

  task automatic test_last_slave();
    @(negedge PCLK); b_transfer = 1; b_rd_wr = 1; b_addr = 9'h100; b_prdata = {8'h5E, 8'h11, 8'h22}; b_pready = 3'b011; #1;
    @(negedge PCLK); b_transfer = 0; b_pready = 3'b111; #1;
    total++; if (b_psel !== 3'b100) begin bad++; $display("FAIL slv2_psel got=%b want=100", b_psel); end
    @(negedge PCLK); #1;
    @(negedge PCLK); b_pready = 3'b000; #1;
    total++; if ({b_rsp_valid, b_rsp_err, b_rd_data} !== {1'b1, 1'b0, 8'h5E}) begin bad++; $display("FAIL slv2_rsp got=%b/%b/%h want=1/0/5e", b_rsp_valid, b_rsp_err, b_rd_data); end
  endtask

  task automatic test_timeout();
    @(negedge PCLK); a_transfer = 1; a_rd_wr = 1; a_addr = 9'h000; a_prdata = 16'h00AA; #1;
    @(negedge PCLK); a_transfer = 0; a_pready = 2'b10; #1;
    for (int i = 0; i < 15; i++) begin
      @(negedge PCLK); #1;
      total++; if ({a_penable, a_req_ready, a_rsp_valid} !== 3'b100) begin bad++; $display("FAIL to_wait%0d got=%b/%b/%b want=1/0/0", i, a_penable, a_req_ready, a_rsp_valid); end
    end
    @(negedge PCLK); #1;
    total++; if ({a_penable, a_psel, a_req_ready} !== 4'b1_01_1) begin bad++; $display("FAIL to_last got=%b/%b/%b want=1/01/1", a_penable, a_psel, a_req_ready); end
    @(negedge PCLK); #1;
    total++; if ({a_rsp_valid, a_rsp_err, a_rd_data} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL to_rsp got=%b/%b/%h want=1/1/00", a_rsp_valid, a_rsp_err, a_rd_data); end
    total++; if ({a_psel, a_penable} !== 3'b000) begin bad++; $display("FAIL to_drop got=%b/%b want=00/0", a_psel, a_penable); end
    a_pready = 2'b00;
  endtask

  task automatic test_back_to_back();
    @(negedge PCLK); a_transfer = 1; a_rd_wr = 0; a_addr = 9'h105; a_wdata = 8'h11; a_prdata = {8'h00, 8'h77}; #1;
    // Second request presented at once; it must wait for the completing cycle.
    @(negedge PCLK); a_rd_wr = 1; a_addr = 9'h000; a_wdata = 8'h00; a_pready = 2'b10; a_pslverr = 2'b00; #1;
    total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL b2b_setup_ready got=%b want=0", a_req_ready); end
    @(negedge PCLK); #1;
    total++; if ({a_req_ready, a_penable, a_psel} !== 4'b1_1_10) begin bad++; $display("FAIL b2b_first_done got=%b/%b/%b want=1/1/10", a_req_ready, a_penable, a_psel); end
    @(negedge PCLK); a_transfer = 0; a_pready = 2'b01; a_pslverr = 2'b01; #1;
    total++; if ({a_psel, a_penable, a_paddr, a_pwrite} !== {2'b01, 1'b0, 9'h000, 1'b0}) begin bad++; $display("FAIL b2b_setup2 got=%b/%b/%h/%b want=01/0/000/0", a_psel, a_penable, a_paddr, a_pwrite); end
    total++; if ({a_rsp_valid, a_rsp_err} !== 2'b10) begin bad++; $display("FAIL b2b_rsp1 got=%b/%b want=1/0", a_rsp_valid, a_rsp_err); end
    @(negedge PCLK); #1;
    total++; if ({a_rsp_valid, a_req_ready} !== 2'b01) begin bad++; $display("FAIL b2b_access2 got=%b/%b want=0/1", a_rsp_valid, a_req_ready); end
    @(negedge PCLK); a_pready = 2'b00; a_pslverr = 2'b00; #1;
    total++; if ({a_rsp_valid, a_rsp_err, a_rd_data} !== {1'b1, 1'b1, 8'h77}) begin bad++; $display("FAIL b2b_rsp2 got=%b/%b/%h want=1/1/77", a_rsp_valid, a_rsp_err, a_rd_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK); a_transfer = 1; a_rd_wr = 0; a_addr = 9'h105; a_wdata = 8'hC3; #1;
    @(negedge PCLK); a_transfer = 0; a_pready = 2'b00; #1;
    @(negedge PCLK); #1;
    total++; if (a_penable !== 1'b1) begin bad++; $display("FAIL rmid_access got=%b want=1", a_penable); end
    PRST = 1; #1;
    total++; if ({a_psel, a_penable, a_paddr, a_pwdata, a_pwrite, a_rsp_valid} !== 22'h0) begin bad++; $display("FAIL rmid_zero got=%b/%b/%h/%h/%b/%b want=0", a_psel, a_penable, a_paddr, a_pwdata, a_pwrite, a_rsp_valid); end
    @(negedge PCLK); PRST = 0; a_pready = 2'b10; #1;
    total++; if ({a_rsp_valid, a_req_ready, a_penable} !== 3'b010) begin bad++; $display("FAIL rmid_release got=%b/%b/%b want=0/1/0", a_rsp_valid, a_req_ready, a_penable); end
    @(negedge PCLK); #1;
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp got=%b want=0", a_rsp_valid); end
    a_transfer = 1; a_rd_wr = 0; a_addr = 9'h105; a_wdata = 8'h5A;
    @(negedge PCLK); a_transfer = 0; #1;
    total++; if ({a_psel, a_pwdata} !== {2'b10, 8'h5A}) begin bad++; $display("FAIL rmid_setup got=%b/%h want=10/5a", a_psel, a_pwdata); end
    @(negedge PCLK); #1;
    @(negedge PCLK); a_pready = 2'b00; #1;
    total++; if ({a_rsp_valid, a_rsp_err} !== 2'b10) begin bad++; $display("FAIL rmid_rsp got=%b/%b want=1/0", a_rsp_valid, a_rsp_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_miss();
    test_last_slave();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_param_bridge.md
APB_PARAM_BRIDGE -- requirements
Module: apb_param_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, address width; DATA_W, default 8, data width; NUM_SLV, default 2, slave count (1..16); SEL_W, default $clog2(NUM_SLV) min 1, slave-index width; TO_CYC, default 16, ACCESS timeout in cycles (>=2).
REQ-002 Ports SHALL be:
- PCLK  in  1  clock, rising edge
- PRST  in  1  reset, asynchronous, active-high
- transfer  in  1  request valid
- RD_WR  in  1  1=read, 0=write
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- req_ready  out  1  request accepted this cycle
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  completion error, valid with rsp_valid
- rd_data  out  DATA_W  read data, valid with rsp_valid on reads
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB enable
- PSEL  out  NUM_SLV  one-hot slave select
- PRDATA_bus  in  NUM_SLV*DATA_W  slave read data, slave k at [k*DATA_W +: DATA_W]
- PREADY_bus  in  NUM_SLV  per-slave ready
- PSLVERR_bus  in  NUM_SLV  per-slave error

Function
REQ-003 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-004 IDLE: req_ready=1; transfer=1 captures req_addr, req_wdata, RD_WR into PADDR/PWDATA/PWRITE (PWRITE=~RD_WR) and moves to SETUP next edge.
REQ-005 Slave index SHALL be PADDR[ADDR_W-1 -: SEL_W]; index < NUM_SLV asserts only that PSEL bit in SETUP and ACCESS.
REQ-006 Index >= NUM_SLV (decode miss) SHALL assert no PSEL bit and complete in the first ACCESS cycle with rsp_err=1, rd_data=0.
REQ-007 SETUP: PENABLE=0, exactly one cycle, then ACCESS.
REQ-008 ACCESS: PENABLE=1; PADDR, PWDATA, PWRITE, PSEL held stable until completion.
REQ-009 Completion SHALL occur in the ACCESS cycle where the selected PREADY is 1: rsp_valid=1, rsp_err=selected PSLVERR, rd_data=selected PRDATA on reads (0 on writes), registered so they appear the cycle after completion.
REQ-010 Wait-state counter SHALL clear on entry to ACCESS, increment each ACCESS cycle with PREADY=0; on reaching TO_CYC-1 without PREADY, transfer SHALL complete with rsp_err=1, rd_data=0, and PSEL/PENABLE drop next cycle.
REQ-011 PSLVERR SHALL be sampled only in the completing ACCESS cycle; ignored otherwise.
REQ-012 On completion: transfer=1 that cycle SHALL be accepted (req_ready=1) and go directly to SETUP (back-to-back, no IDLE cycle); otherwise return to IDLE.
REQ-013 req_ready SHALL be 1 only in IDLE or in a completing ACCESS cycle; requests presented otherwise are not accepted and must be held by the requester.
REQ-014 PSEL/PENABLE SHALL be 0 in IDLE; PENABLE never 1 without a PSEL bit except during decode-miss ACCESS (PENABLE=1, PSEL=0).
REQ-015 PREADY_bus/PRDATA_bus bits of unselected slaves SHALL have no effect.

Reset
REQ-016 PRST=1 SHALL asynchronously force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rd_data=0, counter=0.
REQ-017 Reset mid-transfer SHALL abort it with no rsp_valid; first request after release is accepted in IDLE normally.

Structure
REQ-018 Shared package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and default parameter constants.
REQ-019 Sub-module apb_resp_mux (NUM_SLV:1 select of PRDATA/PREADY/PSLVERR by index, miss flag) SHALL be the only sub-module.

Verification
REQ-020 Write, NUM_SLV=2, addr 0x105, data 0xA5, slave1 PREADY=1 -> PSEL=2'b10, SETUP 1 cycle, ACCESS 1 cycle, rsp_valid=1, rsp_err=0.
REQ-021 Read addr 0x010, slave0 holds PREADY=0 three cycles, PRDATA=0x3C -> ACCESS 4 cycles, PADDR stable, rd_data=0x3C.
REQ-022 NUM_SLV=3, SEL_W=2, addr index 3 -> PSEL=0, rsp_err=1, rd_data=0 after one ACCESS cycle.
REQ-023 TO_CYC=16, PREADY never asserted -> rsp_valid with rsp_err=1 after 16 ACCESS cycles, PSEL=0 next cycle.
REQ-024 transfer held high for two requests -> second SETUP immediately follows first completion; PSLVERR=1 on second -> rsp_err=1 only for second.
REQ-025 PRST asserted mid-ACCESS -> outputs zero immediately, no rsp_valid; next request completes normally.
